fredkin_pipe: RTL and testbench
===============================

Name: fredkin_pipe

Overview:
- Pipelined, parametrised successor of the single-bit Fredkin gate.
- Applies a cascade of STAGES word-wide controlled-swap stages to two WIDTH-bit data words, A and B.
- Each stage swaps the bits of A and B under a per-bit control mask, then rotates B by one bit.
- Runs forward or inverse, selected per transaction, so a forward pass followed by an inverse pass with the same controls restores the original words.
- Controls pass through unchanged, as P = A does in the gate. The block sits between the reversible-logic datapath and any valid/ready producer or consumer.

Parameters:
- WIDTH, 8: data word width in bits (>= 2).
- STAGES, 4: number of Fredkin stages, which is also the pipeline depth (>= 1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept an input this cycle.
- in_a  in  WIDTH  data word A.
- in_b  in  WIDTH  data word B.
- in_c  in  STAGES*WIDTH  control masks; stage k mask = in_c[k*WIDTH +: WIDTH].
- in_dir  in  1  0 = forward, 1 = inverse.
- out_valid  out  1  output transaction valid.
- out_ready  in  1  consumer accepts the output.
- out_a  out  WIDTH  result word P-side A.
- out_b  out  WIDTH  result word B.
- out_c  out  STAGES*WIDTH  control masks passed through unchanged.
- out_dir  out  1  direction passed through.

Behaviour:
- Reset (async assert, sync release): all stage valid bits = 0; out_valid = 0; out_a, out_b, out_c, out_dir = 0; in_ready = 1 after reset.
- Reset mid-operation discards all in-flight transactions; nothing is emitted after release until new input is accepted.
- Forward stage k uses mask m = mask[k]:
  - a' = (a & ~m) | (b & m);
  - b'' = (b & ~m) | (a & m);
  - b' = rotate-left-1(b'').
- Inverse stage k uses mask m = mask[STAGES-1-k]:
  - b'' = rotate-right-1(b);
  - a' = (a & ~m) | (b'' & m);
  - b' = (b'' & ~m) | (a & m).
- Controls and direction travel with the data; each stage latches its own copy.
- One register per stage. Latency from accept to out_valid is STAGES cycles when not stalled.
- Handshake:
  - A transfer occurs when valid && ready at a rising edge.
  - Stage k loads when its valid = 0 or the downstream stage loads/drains in the same cycle.
  - in_ready = (stage0 empty) || stage0 advances this cycle. The ready chain is combinational back to out_ready; no skid buffer.
  - Throughput is 1 transaction per cycle with out_ready held high.
- Stall rules:
  - While out_valid && !out_ready, out_* hold stable.
  - Upstream bubbles are compressed until all stages are full, then in_ready = 0.
- Mixed directions may be interleaved back to back; every transaction is independent.
- Invariants:
  - popcount(out_a) + popcount(out_b) = popcount(in_a) + popcount(in_b) (conservation).
  - An all-zero mask set gives out_a = in_a, and out_b = in_b rotated by STAGES (left in forward, right in inverse).
- Rotation wraps modulo WIDTH. No arithmetic carries.

Decomposition:
- Package fredkin_pkg:
  - function rotl1/rotr1 (WIDTH-parametrised via a parameter on the function's enclosing class or a macro-free generic form);
  - typedef of direction enum { FWD = 1'b0, INV = 1'b1 }.
- Sub-module fredkin_stage: combinational, parameter WIDTH. Inputs a, b, m, dir; outputs a_n, b_n. fredkin_pipe instantiates it STAGES times with per-stage registers and valid/ready control.

Test Plan:
- WIDTH=8, STAGES=2, forward, in_a=0xF0, in_b=0x0F, in_c={0x00, 0xFF} (stage0=0xFF) -> after 2 cycles out_a=0x0F, out_b=0xC3, out_c unchanged, out_dir=0.
- Same config, inverse, in_a=0x0F, in_b=0xC3, same in_c -> out_a=0xF0, out_b=0x0F (round trip restored).
- Random 1000 transactions with mixed in_dir and out_ready held 1 -> one output per cycle, in order, each matching a golden model; popcount conserved on every output.
- out_ready held 0 for 5 cycles after 3 accepts (STAGES=2) -> in_ready drops once 2 are held, out_* stable throughout; on release, outputs drain in order with no loss or duplication.
- All-zero masks, in_a=0x81, in_b=0x01, forward, STAGES=2 -> out_a=0x81, out_b=0x04.
- rst_n pulsed low while 2 transactions are in flight -> out_valid=0 immediately (async); no stale outputs after release; the next accepted input emerges with latency 2.

Source files
------------

// File: rtl/fredkin_pkg.sv
// Shared types and width-generic rotate helpers for the Fredkin pipeline.
// Pure package: no latency, no flow control.
// Rotates operate on the low w bits of a MAX_W container; upper bits must be zero.
package fredkin_pkg;

    localparam int MAX_W = 256;

    typedef logic [MAX_W-1:0] word_t;

    typedef enum logic {
        FWD = 1'b0,
        INV = 1'b1
    } dir_e;

    function automatic word_t low_mask(input int w);
        word_t msk;
        msk = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                msk[i] = 1'b1;
            end
        end
        return msk;
    endfunction

    function automatic word_t rotl1(input word_t x, input int w);
        return ((x << 1) | (x >> (w - 1))) & low_mask(w);
    endfunction

    function automatic word_t rotr1(input word_t x, input int w);
        return ((x >> 1) | (x << (w - 1))) & low_mask(w);
    endfunction

endpackage

// File: rtl/fredkin_stage.sv
// One word-wide controlled-swap stage, forward or inverse.
// Latency: purely combinational.
// Backpressure: none; the enclosing pipeline registers and stalls around it.
module fredkin_stage
    import fredkin_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    input  dir_e             dir,
    output logic [WIDTH-1:0] a_n,
    output logic [WIDTH-1:0] b_n
);

    logic [WIDTH-1:0] b_rot_r;
    logic [WIDTH-1:0] b_pre;
    logic [WIDTH-1:0] b_sw;
    logic [WIDTH-1:0] b_rot_l;

    // Inverse undoes the forward rotate first, then repeats the (self-inverse) swap.
    always_comb begin
        b_rot_r = WIDTH'(rotr1(word_t'(b), WIDTH));
        b_pre   = (dir == INV) ? b_rot_r : b;
        a_n     = (a & ~m) | (b_pre & m);
        b_sw    = (b_pre & ~m) | (a & m);
        b_rot_l = WIDTH'(rotl1(word_t'(b_sw), WIDTH));
        b_n     = (dir == INV) ? b_sw : b_rot_l;
    end

endmodule

// File: rtl/fredkin_pipe.sv
// Pipelined cascade of STAGES Fredkin swap stages on two WIDTH-bit words.
// Latency: STAGES cycles from accept to out_valid, 1 transaction/cycle sustained.
// Backpressure: combinational ready chain from out_ready, bubbles squeezed, no skid buffer.
module fredkin_pipe
    import fredkin_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_a,
    input  logic [WIDTH-1:0]        in_b,
    input  logic [STAGES*WIDTH-1:0] in_c,
    input  logic                    in_dir,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_a,
    output logic [WIDTH-1:0]        out_b,
    output logic [STAGES*WIDTH-1:0] out_c,
    output logic                    out_dir
);

    localparam int CW = STAGES * WIDTH;

    if (WIDTH < 2 || WIDTH > MAX_W || STAGES < 1) begin : g_param_check
        $error("fredkin_pipe: WIDTH must be 2..MAX_W and STAGES >= 1");
    end

    logic [STAGES-1:0]            st_vld;
    logic [STAGES-1:0][WIDTH-1:0] st_a;
    logic [STAGES-1:0][WIDTH-1:0] st_b;
    logic [STAGES-1:0][CW-1:0]    st_c;
    logic [STAGES-1:0]            st_dir;

    logic [STAGES-1:0]            src_vld;
    logic [STAGES-1:0][WIDTH-1:0] src_a;
    logic [STAGES-1:0][WIDTH-1:0] src_b;
    logic [STAGES-1:0][CW-1:0]    src_c;
    logic [STAGES-1:0]            src_dir;

    logic [STAGES-1:0][WIDTH-1:0] mask;
    logic [STAGES-1:0][WIDTH-1:0] nxt_a;
    logic [STAGES-1:0][WIDTH-1:0] nxt_b;
    logic [STAGES-1:0]            ld;

    // Stage k is fed by the input port (k == 0) or by the register of stage k-1.
    always_comb begin
        src_vld[0] = in_valid;
        src_a[0]   = in_a;
        src_b[0]   = in_b;
        src_c[0]   = in_c;
        src_dir[0] = in_dir;
        for (int k = 1; k < STAGES; k++) begin
            src_vld[k] = st_vld[k-1];
            src_a[k]   = st_a[k-1];
            src_b[k]   = st_b[k-1];
            src_c[k]   = st_c[k-1];
            src_dir[k] = st_dir[k-1];
        end
    end

    // A stage may load if it is empty or its contents move on this same cycle.
    always_comb begin
        logic chain;
        chain = out_ready;
        ld    = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ld[k] = !st_vld[k] || chain;
            chain = ld[k];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Inverse walks the mask list backwards so it retraces a forward pass.
        assign mask[k] = src_dir[k] ? src_c[k][(STAGES-1-k)*WIDTH +: WIDTH]
                                    : src_c[k][k*WIDTH +: WIDTH];

        fredkin_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .a   (src_a[k]),
            .b   (src_b[k]),
            .m   (mask[k]),
            .dir (dir_e'(src_dir[k])),
            .a_n (nxt_a[k]),
            .b_n (nxt_b[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_vld <= '0;
            st_a   <= '0;
            st_b   <= '0;
            st_c   <= '0;
            st_dir <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    st_vld[k] <= src_vld[k];
                    if (src_vld[k]) begin
                        st_a[k]   <= nxt_a[k];
                        st_b[k]   <= nxt_b[k];
                        st_c[k]   <= src_c[k];
                        st_dir[k] <= src_dir[k];
                    end
                end
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = st_vld[STAGES-1];
    assign out_a     = st_a[STAGES-1];
    assign out_b     = st_b[STAGES-1];
    assign out_c     = st_c[STAGES-1];
    assign out_dir   = st_dir[STAGES-1];

endmodule

// File: tb/tb_fredkin_pipe.sv
// Scoreboard bench for fredkin_pipe (WIDTH=8, STAGES=2): directed vectors,
// random mixed-direction stream, stall and mid-flight reset.
module tb_fredkin_pipe;

    localparam int W = 8;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic [S*W-1:0] in_c = '0;
    logic           in_dir = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_a;
    logic [W-1:0]   out_b;
    logic [S*W-1:0] out_c;
    logic           out_dir;

    fredkin_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_dir   (out_dir)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [S*W-1:0] c;
        logic           dir;
        int             acc;
        bit             lat;
        int             pc;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                                  input logic [S*W-1:0] c, input logic d,
                                  output logic [W-1:0] oa, output logic [W-1:0] ob);
        logic [W-1:0] a, b, m, t, na;
        a = a_i;
        b = b_i;
        for (int s = 0; s < S; s++) begin
            m = d ? c[(S-1-s)*W +: W] : c[s*W +: W];
            if (!d) begin
                na = (a & ~m) | (b & m);
                t  = (b & ~m) | (a & m);
                b  = {t[W-2:0], t[W-1]};
                a  = na;
            end else begin
                t  = {b[0], b[W-1:1]};
                na = (a & ~m) | (t & m);
                b  = (t & ~m) | (a & m);
                a  = na;
            end
        end
        oa = a;
        ob = b;
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [S*W-1:0] c,
                        input logic d, input logic [W-1:0] ea, input logic [W-1:0] eb,
                        input bit lat, input bit imm);
        int   waits = 0;
        bit   acc = 0;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_c = c;
        in_dir = d;
        while (!acc && waits < 50) begin
            #1;
            if (in_ready) begin
                acc = 1;
                e.a = ea; e.b = eb; e.c = c; e.dir = d;
                e.acc = cyc; e.lat = lat;
                e.pc = $countones(a) + $countones(b);
                q.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end else begin
                @(negedge clk);
                waits++;
            end
        end
        if (!acc) begin
            vectors++;
            errors++;
            $display("FAIL accept_timeout: input never accepted after %0d cycles, required within 50", waits);
            in_valid = 1'b0;
        end else if (imm) begin
            check("in_ready_immediate_waits", 32'(waits), 32'd0);
        end
    endtask

    task automatic drain;
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #3;
        check("drain_queue_empty", 32'(q.size()), 32'd0);
    endtask

    // Monitor: pops and compares on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_output: got a=%h b=%h, required no output", out_a, out_b);
                end else begin
                    e = q.pop_front();
                    check("out_a", 32'(out_a), 32'(e.a));
                    check("out_b", 32'(out_b), 32'(e.b));
                    check("out_c", 32'(out_c), 32'(e.c));
                    check("out_dir", 32'(out_dir), 32'(e.dir));
                    check("popcount", 32'($countones(out_a) + $countones(out_b)), 32'(e.pc));
                    if (e.lat) check("latency", 32'(cyc - e.acc), 32'(S));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0]   ra, rb, ea, eb, snap_a, snap_b;
        logic [S*W-1:0] rc;
        logic           rd;
        exp_t           e;

        // Reset state
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_a", 32'(out_a), 32'd0);
        check("rst_out_b", 32'(out_b), 32'd0);
        check("rst_out_c", 32'(out_c), 32'd0);
        check("rst_out_dir", 32'(out_dir), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Directed vectors with hand-computed results
        send(8'hF0, 8'h0F, 16'h00FF, 1'b0, 8'h0F, 8'hC3, 1, 1);
        send(8'h0F, 8'hC3, 16'h00FF, 1'b1, 8'hF0, 8'h0F, 1, 1);
        send(8'h81, 8'h01, 16'h0000, 1'b0, 8'h81, 8'h04, 1, 1);
        send(8'h81, 8'h01, 16'h0000, 1'b1, 8'h81, 8'h40, 1, 1);
        drain();

        // Random mixed-direction stream, one per cycle
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 16'($urandom);
            rd = 1'($urandom_range(0, 1));
            model(ra, rb, rc, rd, ea, eb);
            send(ra, rb, rc, rd, ea, eb, 1, 1);
        end
        drain();

        // Stall: 2 held in pipe, third blocked, outputs frozen
        @(negedge clk);
        out_ready = 1'b0;
        send(8'hF0, 8'h0F, 16'h00FF, 1'b0, 8'h0F, 8'hC3, 0, 1);
        send(8'h0F, 8'hC3, 16'h00FF, 1'b1, 8'hF0, 8'h0F, 0, 1);
        @(negedge clk);
        in_valid = 1'b1;
        in_a = 8'h81; in_b = 8'h01; in_c = 16'h0000; in_dir = 1'b0;
        #1;
        snap_a = out_a;
        snap_b = out_b;
        check("stall_head_a", 32'(out_a), 32'h0F);
        check("stall_head_b", 32'(out_b), 32'hC3);
        for (int i = 0; i < 5; i++) begin
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_hold_a", 32'(out_a), 32'(snap_a));
            check("stall_hold_b", 32'(out_b), 32'(snap_b));
            check("stall_hold_c", 32'(out_c), 32'h00FF);
            @(negedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        e.a = 8'h81; e.b = 8'h04; e.c = 16'h0000; e.dir = 1'b0;
        e.acc = cyc; e.lat = 0; e.pc = 3;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Reset with two transactions in flight
        @(negedge clk);
        out_ready = 1'b0;
        send(8'h12, 8'h34, 16'h5A5A, 1'b0, 8'h00, 8'h00, 0, 1);
        send(8'h56, 8'h78, 16'hA5A5, 1'b1, 8'h00, 8'h00, 0, 1);
        @(negedge clk);
        #1;
        check("inflight_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        check("async_rst_out_a", 32'(out_a), 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("post_rst_no_stale", 32'(out_valid), 32'd0);
        end
        send(8'hF0, 8'h0F, 16'h00FF, 1'b0, 8'h0F, 8'hC3, 1, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
